// File: rtl/pong_pkg.sv
// Shared types and constants for the position-frame scheduler.
// The frame is a header byte, a little-endian payload, then an XOR checksum.
package pong_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT    = 8'hA5;
  localparam int unsigned FRAME_PAYLOAD_BYTES = 4;

  localparam int unsigned IDX_W = $clog2(FRAME_PAYLOAD_BYTES);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t IDX_LAST = idx_t'(FRAME_PAYLOAD_BYTES - 1);

  typedef logic [8*FRAME_PAYLOAD_BYTES-1:0] pos_t;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CSUM
  } asm_state_t;

endpackage

// File: rtl/pos_frame_sched_if.sv
// UART-byte input, vsync input and render-side outputs of the scheduler.
// The master side drives bytes and vsync; the slave side is the scheduler.
interface pos_frame_sched_if;

  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           n_vsync;
  pong_pkg::pos_t render_pos;
  logic           pos_update;
  logic           pending;
  logic           frame_err;
  logic           frame_drop;

  modport master (
    output rx_data, rx_valid, n_vsync,
    input  render_pos, pos_update, pending, frame_err, frame_drop
  );

  modport slave (
    input  rx_data, rx_valid, n_vsync,
    output render_pos, pos_update, pending, frame_err, frame_drop
  );

endinterface

// File: rtl/pos_frame_asm.sv
// Frame assembler: hunts for the header, shifts in the payload, checks the XOR
// checksum and aborts a frame that goes quiet for too long.
module pos_frame_asm
  import pong_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output pos_t       o_word,
  output logic       o_word_valid,
  output logic       o_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  asm_state_t    r_state;
  idx_t          r_idx;
  pos_t          r_word;
  logic [7:0]    r_csum;
  logic [TW-1:0] r_tmo;
  logic          r_word_valid;
  logic          r_err;

  // NOTE: every register here is updated with <= so all reads within one edge
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= HUNT;
      r_idx        <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_tmo        <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;

      if (r_state == HUNT) begin
        r_tmo <= '0;
        if (i_rx_valid && (i_rx_data == HDR_BYTE)) begin
          r_state <= PAYLOAD;
          r_idx   <= '0;
          r_csum  <= '0;
        end
      end else if (!i_rx_valid) begin
        // A byte arriving in the expiry cycle takes the other branch and wins.
        if (r_tmo == TMO_LAST) begin
          r_state <= HUNT;
          r_err   <= 1'b1;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
        case (r_state)
          PAYLOAD: begin
            // Little-endian: after the last shift P0 sits in bits [7:0].
            r_word <= {i_rx_data, r_word[$bits(pos_t)-1:8]};
            r_csum <= r_csum ^ i_rx_data;
            if (r_idx == IDX_LAST) r_state <= CSUM;
            else                   r_idx   <= r_idx + 1'b1;
          end
          CSUM: begin
            r_state <= HUNT;
            if (i_rx_data == r_csum) r_word_valid <= 1'b1;
            else                     r_err        <= 1'b1;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_err        = r_err;

endmodule

// File: rtl/pos_frame_sched.sv
// Position scheduler top: keeps the latest validated word pending and commits
// it to the render side once per video frame, on the falling edge of n_vsync.
module pos_frame_sched
  import pong_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter pos_t        RESET_POS      = '0
) (
  input logic              i_clk,
  input logic              i_rst_n,
  pos_frame_sched_if.slave bus
);

  pos_t w_word;
  logic w_word_valid;
  logic w_err;
  logic w_vs_fall;

  logic r_vs_hist;
  pos_t r_pend_word;
  logic r_pending;
  pos_t r_render_pos;
  logic r_pos_update;
  logic r_frame_drop;

  pos_frame_asm #(
    .HDR_BYTE       (HDR_BYTE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (bus.rx_data),
    .i_rx_valid   (bus.rx_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_err        (w_err)
  );

  assign w_vs_fall = r_vs_hist & ~bus.n_vsync;

  // NOTE: the pending word is a data register but still gets a reset value,
  // so a commit can never expose whatever the flops powered up with.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_hist    <= 1'b1;
      r_pend_word  <= '0;
      r_pending    <= 1'b0;
      r_render_pos <= RESET_POS;
      r_pos_update <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_vs_hist    <= bus.n_vsync;
      r_pos_update <= 1'b0;
      r_frame_drop <= 1'b0;

      if (w_vs_fall && r_pending) begin
        r_render_pos <= r_pend_word;
        r_pos_update <= 1'b1;
        r_pending    <= 1'b0;
      end

      // Placed after the commit so a word arriving on the vsync edge stays
      // pending; it only counts as a drop if nothing was committed.
      if (w_word_valid) begin
        r_pend_word <= w_word;
        r_pending   <= 1'b1;
        if (r_pending && !w_vs_fall) r_frame_drop <= 1'b1;
      end
    end
  end

  assign bus.render_pos = r_render_pos;
  assign bus.pos_update = r_pos_update;
  assign bus.pending    = r_pending;
  assign bus.frame_err  = w_err;
  assign bus.frame_drop = r_frame_drop;

endmodule

// File: tb/tb_pos_frame_sched.sv
// Self-checking bench for pos_frame_sched: directed scenarios then random
// traffic, scored per clock edge against a frame-level reference model.
module tb_pos_frame_sched;
  import pong_pkg::*;

  localparam logic [7:0] HDR    = 8'hA5;
  localparam int         TMO    = 16;
  localparam pos_t       RST_PV = 32'hC0DE_0001;

  typedef struct packed {
    pos_t render_pos;
    logic pending;
    logic pos_update;
    logic frame_err;
    logic frame_drop;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pos_frame_sched_if bus ();

  pos_frame_sched #(
    .HDR_BYTE       (HDR),
    .TIMEOUT_CYCLES (TMO),
    .RESET_POS      (RST_PV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];
  bit   mon_en   = 1'b0;
  logic cur_nvs  = 1'b1;
  bit   auto_vs  = 1'b0;
  int   vs_ctr   = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (render_pos|pend|upd|err|drop)", name, act, exp);
  endtask

  // Reference model: frame bytes collected in a queue, checksum by XOR-reduce,
  // idle gaps counted; commit/pending rules applied one clock later.
  logic [7:0] m_bytes[$];
  bit         m_in_frame;
  int         m_idle;
  bit         m_pending;
  pos_t       m_pend_word;
  pos_t       m_render;
  bit         m_new_valid;
  pos_t       m_new_word;
  logic       m_prev_nvs;

  function automatic void model_reset();
    m_bytes.delete();
    m_in_frame  = 1'b0;
    m_idle      = 0;
    m_pending   = 1'b0;
    m_pend_word = '0;
    m_render    = RST_PV;
    m_new_valid = 1'b0;
    m_new_word  = '0;
    m_prev_nvs  = 1'b1;
  endfunction

  function automatic obs_t model_step(input logic v, input logic [7:0] d, input logic nvs);
    obs_t       e;
    logic       vs_fall;
    logic [7:0] x;
    e          = '0;
    vs_fall    = m_prev_nvs && !nvs;
    m_prev_nvs = nvs;

    if (vs_fall && m_pending) begin
      m_render     = m_pend_word;
      e.pos_update = 1'b1;
      m_pending    = 1'b0;
    end
    if (m_new_valid) begin
      if (m_pending) e.frame_drop = 1'b1;
      m_pending   = 1'b1;
      m_pend_word = m_new_word;
    end
    m_new_valid = 1'b0;

    if (!m_in_frame) begin
      if (v && d == HDR) begin
        m_in_frame = 1'b1;
        m_bytes.delete();
        m_idle = 0;
      end
    end else if (v) begin
      m_idle = 0;
      m_bytes.push_back(d);
      if (m_bytes.size() == 5) begin
        x = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
        if (x == m_bytes[4]) begin
          m_new_valid = 1'b1;
          m_new_word  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        end else begin
          e.frame_err = 1'b1;
        end
        m_in_frame = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e.frame_err = 1'b1;
        m_in_frame  = 1'b0;
      end
    end

    e.render_pos = m_render;
    e.pending    = m_pending;
    return e;
  endfunction

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin : monitor
    obs_t a;
    obs_t e;
    int   edge_no;
    #1;
    if (mon_en) begin
      edge_no++;
      a = '{bus.render_pos, bus.pending, bus.pos_update, bus.frame_err, bus.frame_drop};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard@edge%0d: DUT output %h with no expected entry", edge_no, a);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("outputs@edge%0d", edge_no), a, e);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    if (auto_vs) begin
      vs_ctr++;
      cur_nvs = ((vs_ctr % 37) >= 3);
    end
    bus.rx_valid = v;
    bus.rx_data  = v ? d : 8'($urandom);
    bus.n_vsync  = cur_nvs;
    exp_q.push_back(model_step(v, bus.rx_data, cur_nvs));
    mon_en = 1'b1;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    drive(v, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic vsync(input int low);
    cur_nvs = 1'b0;
    idle(low);
    cur_nvs = 1'b1;
    idle(1);
  endtask

  task automatic send_frame(input pos_t w, input bit bad, input int gap_max);
    logic [7:0] b[6];
    b[0] = HDR;
    b[1] = w[7:0];
    b[2] = w[15:8];
    b[3] = w[23:16];
    b[4] = w[31:24];
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    if (bad) b[5] = b[5] ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, b[i]);
      repeat ($urandom_range(0, gap_max)) step(1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en       = 1'b0;
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    check("rst_render_pos", 36'(bus.render_pos), 36'(RST_PV));
    check("rst_pending",    36'(bus.pending),    36'(0));
    check("rst_pos_update", 36'(bus.pos_update), 36'(0));
    check("rst_frame_err",  36'(bus.frame_err),  36'(0));
    check("rst_frame_drop", 36'(bus.frame_drop), 36'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    drive(1'b0, 8'h00);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.n_vsync  = 1'b1;
    do_reset();

    // Vsync with nothing pending.
    idle(4);
    vsync(3);
    idle(2);

    // Good frame then commit.
    send_frame(32'h1234_5678, 1'b0, 0);
    idle(3);
    vsync(3);

    // Bad checksum, then the corrected frame.
    send_frame(32'h0403_0201, 1'b1, 0);
    idle(2);
    send_frame(32'h0403_0201, 1'b0, 0);
    idle(2);
    vsync(2);

    // Two frames before vsync: the second replaces the first.
    send_frame(32'h1111_1111, 1'b0, 0);
    idle(1);
    send_frame(32'h2222_2222, 1'b0, 0);
    idle(2);
    vsync(2);

    // Stalled frame times out, a later frame is still accepted.
    step(1'b1, HDR);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    idle(TMO);
    idle(2);
    send_frame(32'h5566_7788, 1'b0, 1);
    vsync(2);

    // Checksum byte lands on the vsync fall while DEADBEEF is pending.
    send_frame(32'hDEAD_BEEF, 1'b0, 0);
    idle(2);
    step(1'b1, HDR);
    step(1'b1, 8'hFE);
    step(1'b1, 8'hCA);
    step(1'b1, 8'hAD);
    step(1'b1, 8'h0B);
    cur_nvs = 1'b0;
    step(1'b1, 8'hFE ^ 8'hCA ^ 8'hAD ^ 8'h0B);
    idle(3);
    cur_nvs = 1'b1;
    idle(1);

    // Reset in the middle of a payload.
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    do_reset();
    idle(2);

    // Random traffic with a free-running vsync.
    auto_vs = 1'b1;
    repeat (200) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: send_frame(pos_t'($urandom), ($urandom_range(0, 4) == 0), 2);
        5:             step(1'b1, 8'($urandom));
        6:             idle($urandom_range(1, 20));
        7: begin
          step(1'b1, HDR);
          repeat ($urandom_range(0, 3)) step(1'b1, 8'($urandom));
          idle(TMO + $urandom_range(0, 2));
        end
        default:       send_frame(pos_t'($urandom), 1'b0, 0);
      endcase
    end
    idle(40);

    @(negedge clk);
    mon_en = 1'b0;
    check("scoreboard_drained", 36'(exp_q.size()), 36'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
